// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game blocks.
// - FSM state codes (IDLE/RUN/OVER) as legacy-compatible 2-bit constants.
// - Screen clamp limits of the bird-motion block (Y_MIN/Y_MAX).
// - Default bird column, bird half-size and pipe width.
// - sat_sub: 11-bit subtraction that floors at zero.
package flappy_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam logic [9:0] Y_MIN = 10'd15;
  localparam logic [9:0] Y_MAX = 10'd465;

  localparam logic [9:0] BIRD_X_DEF    = 10'd100;
  localparam logic [9:0] BIRD_HALF_DEF = 10'd10;
  localparam logic [9:0] PIPE_W_DEF    = 10'd40;

  function automatic logic [10:0] sat_sub(input logic [10:0] a, input logic [10:0] b);
    return (a > b) ? (a - b) : 11'd0;
  endfunction

endpackage

// File: rtl/pipe_pass_detector.sv
// Detects the bird clearing a pipe and emits a one-cycle pass pulse.
// The armed flag allows one pass per pipe; it re-arms once the pipe is no
// longer behind the bird (covers the wrap back to the right edge).
// Ports:
//   clk10      - game clock
//   clr        - synchronous active-low reset (armed goes to 1)
//   en         - high only while the game is running
//   rearm      - forces armed on game (re)start
//   hit        - collision this cycle; suppresses the pass
//   pipe_right - right-most pipe column, 11-bit
//   bird_left  - left-most bird column, 11-bit
//   pass       - combinational pulse, valid on the deciding edge
module pipe_pass_detector (
  input  logic        clk10,
  input  logic        clr,
  input  logic        en,
  input  logic        rearm,
  input  logic        hit,
  input  logic [10:0] pipe_right,
  input  logic [10:0] bird_left,
  output logic        pass
);

  logic armed_q, armed_d;
  logic past;

  always_comb begin
    past    = pipe_right < bird_left;
    pass    = en & armed_q & past & ~hit;
    armed_d = armed_q;
    if (rearm) begin
      armed_d = 1'b1;
    end else if (en) begin
      if (!past) begin
        armed_d = 1'b1;
      end else if (pass) begin
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk10) begin
    if (!clr) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/bird_collision_fsm.sv
// Game-state controller: decides game_end from bird height and pipe geometry,
// counts passed pipes and sequences start/restart with a minimum OVER dwell.
// Optional macro BOUNDARY_KILL_EN: touching the floor/ceiling clamp is fatal.
// Ports:
//   clk10      - 10 Hz game clock
//   clr        - synchronous active-low reset
//   start      - start/restart request, level-sampled
//   bird_y_pos - bird centre row
//   pipe_x_pos - left edge of the active pipe
//   gap_top    - first open row of the gap
//   gap_bot    - last open row of the gap
//   game_end   - registered, high in IDLE and OVER
//   score      - registered pass count, saturates at 255
//   state      - IDLE=0, RUN=1, OVER=2
module bird_collision_fsm
  import flappy_pkg::*;
#(
  parameter logic [9:0] BIRD_X      = BIRD_X_DEF,
  parameter logic [9:0] BIRD_HALF   = BIRD_HALF_DEF,
  parameter logic [9:0] PIPE_W      = PIPE_W_DEF,
  parameter logic [7:0] HOLD_CYCLES = 8'd20
) (
  input  logic       clk10,
  input  logic       clr,
  input  logic       start,
  input  logic [9:0] bird_y_pos,
  input  logic [9:0] pipe_x_pos,
  input  logic [9:0] gap_top,
  input  logic [9:0] gap_bot,
  output logic       game_end,
  output logic [7:0] score,
  output logic [1:0] state
);

  logic [1:0]  state_q, state_d;
  logic        game_end_q, game_end_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  hold_q, hold_d;

  logic [10:0] bird_top, bird_bot, bird_left, bird_right, pipe_left, pipe_right;
  logic        x_ov, edge_hit, hit, run, rearm, pass;

  // Geometry in 11 bits so sums cannot wrap; bird edges floor at zero.
  always_comb begin
    bird_top   = sat_sub({1'b0, bird_y_pos}, {1'b0, BIRD_HALF});
    bird_bot   = {1'b0, bird_y_pos} + {1'b0, BIRD_HALF};
    bird_left  = sat_sub({1'b0, BIRD_X}, {1'b0, BIRD_HALF});
    bird_right = {1'b0, BIRD_X} + {1'b0, BIRD_HALF};
    pipe_left  = {1'b0, pipe_x_pos};
    pipe_right = {1'b0, pipe_x_pos} + {1'b0, PIPE_W} - 11'd1;
    x_ov       = (pipe_left <= bird_right) && (pipe_right >= bird_left);
  end

`ifdef BOUNDARY_KILL_EN
  assign edge_hit = (bird_y_pos <= Y_MIN) || (bird_y_pos >= Y_MAX);
`else
  assign edge_hit = 1'b0;
`endif

  // An inverted gap (gap_top > gap_bot) makes every overlapping cycle a hit.
  assign hit = edge_hit ||
               (x_ov && ((bird_top < {1'b0, gap_top}) || (bird_bot > {1'b0, gap_bot})));
  assign run = (state_q == ST_RUN);

  pipe_pass_detector u_pass (
    .clk10      (clk10),
    .clr        (clr),
    .en         (run),
    .rearm      (rearm),
    .hit        (hit),
    .pipe_right (pipe_right),
    .bird_left  (bird_left),
    .pass       (pass)
  );

  always_comb begin
    state_d    = state_q;
    game_end_d = game_end_q;
    score_d    = score_q;
    hold_d     = hold_q;
    rearm      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        game_end_d = 1'b1;
        if (start) begin
          state_d    = ST_RUN;
          game_end_d = 1'b0;
          score_d    = 8'd0;
          rearm      = 1'b1;
        end
      end
      ST_RUN: begin
        game_end_d = 1'b0;
        if (hit) begin
          state_d    = ST_OVER;
          game_end_d = 1'b1;
          hold_d     = 8'd0;
        end else if (pass && (score_q != 8'hff)) begin
          score_d = score_q + 8'd1;
        end
      end
      ST_OVER: begin
        game_end_d = 1'b1;
        if (hold_q != HOLD_CYCLES) begin
          hold_d = hold_q + 8'd1;
        end
        if ((hold_q == HOLD_CYCLES) && start) begin
          state_d    = ST_RUN;
          game_end_d = 1'b0;
          score_d    = 8'd0;
          rearm      = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        game_end_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk10) begin
    if (!clr) begin
      state_q    <= ST_IDLE;
      game_end_q <= 1'b1;
      score_q    <= 8'd0;
      hold_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      game_end_q <= game_end_d;
      score_q    <= score_d;
      hold_q     <= hold_d;
    end
  end

  assign game_end = game_end_q;
  assign score    = score_q;
  assign state    = state_q;

endmodule

// File: tb/tb_bird_collision_fsm.sv
module tb_bird_collision_fsm;

  logic       clk10 = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic [9:0] bird_y_pos = 10'd200;
  logic [9:0] pipe_x_pos = 10'd300;
  logic [9:0] gap_top = 10'd150;
  logic [9:0] gap_bot = 10'd260;
  logic       game_end;
  logic [7:0] score;
  logic [1:0] state;

  wire [10:0] obs = {state, game_end, score};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integers, rules applied directly.
  int m_state = 0;
  int m_ge    = 1;
  int m_score = 0;
  int m_armed = 1;
  int m_hold  = 0;

  bird_collision_fsm dut (
    .clk10      (clk10),
    .clr        (clr),
    .start      (start),
    .bird_y_pos (bird_y_pos),
    .pipe_x_pos (pipe_x_pos),
    .gap_top    (gap_top),
    .gap_bot    (gap_bot),
    .game_end   (game_end),
    .score      (score),
    .state      (state)
  );

  always #5 clk10 = ~clk10;

  function automatic logic [10:0] pack(input int st, input int ge, input int sc);
    pack = {st[1:0], ge[0], sc[7:0]};
  endfunction

  // One clock edge; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    int by, px, gt, gb, top, hit, past;
    @(posedge clk10);
    by = int'(bird_y_pos);
    px = int'(pipe_x_pos);
    gt = int'(gap_top);
    gb = int'(gap_bot);
    if (!clr) begin
      m_state = 0; m_ge = 1; m_score = 0; m_armed = 1; m_hold = 0;
    end else if (m_state == 0) begin
      if (start) begin
        m_state = 1; m_ge = 0; m_score = 0; m_armed = 1;
      end
    end else if (m_state == 1) begin
      top  = (by > 10) ? by - 10 : 0;
      hit  = ((px <= 110) && (px + 39 >= 90) && ((top < gt) || (by + 10 > gb))) ? 1 : 0;
`ifdef BOUNDARY_KILL_EN
      if (by <= 15 || by >= 465) hit = 1;
`endif
      past = (px + 39 < 90) ? 1 : 0;
      if (hit != 0) begin
        m_state = 2; m_ge = 1; m_hold = 0;
      end else if (m_armed != 0 && past != 0) begin
        if (m_score < 255) m_score++;
        m_armed = 0;
      end
      if (past == 0) m_armed = 1;
    end else begin
      if (m_hold == 20 && start) begin
        m_state = 1; m_ge = 0; m_score = 0; m_armed = 1;
      end else if (m_hold < 20) begin
        m_hold++;
      end
    end
    #1;
  endtask

  task automatic reset_and_start();
    clr = 1'b0; start = 1'b0;
    tick();
    clr = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0; start = 1'b1;
    tick();
    n_checks++;
    if (obs !== pack(0, 1, 0)) begin
      n_fail++;
      $display("FAIL reset: got st=%0d ge=%0d sc=%0d, want st=0 ge=1 sc=0",
               obs[10:9], obs[8], obs[7:0]);
    end
    clr = 1'b1; start = 1'b0;
    tick();
    n_checks++;
    if (obs !== pack(0, 1, 0)) begin
      n_fail++;
      $display("FAIL idle_hold: got st=%0d ge=%0d sc=%0d, want st=0 ge=1 sc=0",
               obs[10:9], obs[8], obs[7:0]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (obs !== pack(1, 0, 0)) begin
      n_fail++;
      $display("FAIL start: got st=%0d ge=%0d sc=%0d, want st=1 ge=0 sc=0",
               obs[10:9], obs[8], obs[7:0]);
    end
  endtask

  task automatic test_sweep();
    int exp_sc;
    bird_y_pos = 10'd200; gap_top = 10'd150; gap_bot = 10'd260;
    for (int x = 300; x >= 0; x -= 6) begin
      pipe_x_pos = 10'(x);
      tick();
      exp_sc = (x + 39 < 90) ? 1 : 0;
      n_checks++;
      if (obs !== pack(1, 0, exp_sc)) begin
        n_fail++;
        $display("FAIL sweep x=%0d: got st=%0d ge=%0d sc=%0d, want st=1 ge=0 sc=%0d",
                 x, obs[10:9], obs[8], obs[7:0], exp_sc);
      end
    end
  endtask

  // Entered with score 1 from the sweep.
  task automatic test_collision_hold();
    bird_y_pos = 10'd100; pipe_x_pos = 10'd95; start = 1'b1;
    tick();
    n_checks++;
    if (obs !== pack(2, 1, 1)) begin
      n_fail++;
      $display("FAIL hit: got st=%0d ge=%0d sc=%0d, want st=2 ge=1 sc=1",
               obs[10:9], obs[8], obs[7:0]);
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_checks++;
      if (obs !== pack(2, 1, 1)) begin
        n_fail++;
        $display("FAIL hold edge %0d: got st=%0d ge=%0d sc=%0d, want st=2 ge=1 sc=1",
                 i, obs[10:9], obs[8], obs[7:0]);
      end
    end
    tick();
    n_checks++;
    if (obs !== pack(1, 0, 0)) begin
      n_fail++;
      $display("FAIL restart: got st=%0d ge=%0d sc=%0d, want st=1 ge=0 sc=0",
               obs[10:9], obs[8], obs[7:0]);
    end
    start = 1'b0; bird_y_pos = 10'd200; pipe_x_pos = 10'd300;
  endtask

  task automatic test_pass_and_hit();
    int exp_st, exp_sc;
    tick();
    // Pipe fully behind the bird: a pass, no overlap, so no pipe hit.
    bird_y_pos = 10'd140; pipe_x_pos = 10'd50;
    tick();
    n_checks++;
    if (obs !== pack(1, 0, 1)) begin
      n_fail++;
      $display("FAIL pass_low_bird: got st=%0d ge=%0d sc=%0d, want st=1 ge=0 sc=1",
               obs[10:9], obs[8], obs[7:0]);
    end
    bird_y_pos = 10'd200; pipe_x_pos = 10'd300;
    tick();
    // Pass coinciding with a floor touch.
    bird_y_pos = 10'd465; pipe_x_pos = 10'd50;
    tick();
`ifdef BOUNDARY_KILL_EN
    exp_st = 2; exp_sc = 1;
`else
    exp_st = 1; exp_sc = 2;
`endif
    n_checks++;
    if (obs !== pack(exp_st, exp_st == 2 ? 1 : 0, exp_sc)) begin
      n_fail++;
      $display("FAIL pass_and_hit: got st=%0d ge=%0d sc=%0d, want st=%0d sc=%0d",
               obs[10:9], obs[8], obs[7:0], exp_st, exp_sc);
    end
  endtask

  task automatic test_boundary();
    int exp_ge;
    reset_and_start();
    gap_top = 10'd150; gap_bot = 10'd260; pipe_x_pos = 10'd300; bird_y_pos = 10'd465;
`ifdef BOUNDARY_KILL_EN
    exp_ge = 1;
`else
    exp_ge = 0;
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== pack(exp_ge == 1 ? 2 : 1, exp_ge, 0)) begin
        n_fail++;
        $display("FAIL boundary %0d: got st=%0d ge=%0d sc=%0d, want ge=%0d",
                 i, obs[10:9], obs[8], obs[7:0], exp_ge);
      end
    end
    bird_y_pos = 10'd200;
  endtask

  task automatic test_clr_mid_run();
    reset_and_start();
    bird_y_pos = 10'd200; gap_top = 10'd150; gap_bot = 10'd260;
    for (int i = 0; i < 7; i++) begin
      pipe_x_pos = 10'd300;
      tick();
      pipe_x_pos = 10'd0;
      tick();
    end
    n_checks++;
    if (obs !== pack(1, 0, 7)) begin
      n_fail++;
      $display("FAIL seven_passes: got st=%0d ge=%0d sc=%0d, want st=1 ge=0 sc=7",
               obs[10:9], obs[8], obs[7:0]);
    end
    clr = 1'b0; start = 1'b1;
    tick();
    n_checks++;
    if (obs !== pack(0, 1, 0)) begin
      n_fail++;
      $display("FAIL clr_mid_run: got st=%0d ge=%0d sc=%0d, want st=0 ge=1 sc=0",
               obs[10:9], obs[8], obs[7:0]);
    end
    clr = 1'b1; start = 1'b0;
  endtask

  task automatic test_random();
    int by, px, r;
    by = 200; px = 400;
    reset_and_start();
    for (int i = 0; i < 800; i++) begin
      by += int'($urandom_range(0, 20)) - 10;
      if (by < 12) by = 12;
      if (by > 468) by = 468;
      px -= int'($urandom_range(1, 9));
      if (px < 0) px = 400 + int'($urandom_range(0, 200));
      if ($urandom_range(0, 9) < 8) begin
        r = int'($urandom_range(0, 40));
        gap_top = 10'((by - 10 - r < 0) ? 0 : by - 10 - r);
        gap_bot = 10'(by + 10 + r);
      end else begin
        gap_top = 10'($urandom_range(0, 479));
        gap_bot = 10'($urandom_range(0, 479));
      end
      bird_y_pos = 10'(by);
      pipe_x_pos = 10'(px);
      start = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 149) != 0);
      tick();
      n_checks++;
      if (obs !== pack(m_state, m_ge, m_score)) begin
        n_fail++;
        $display("FAIL random %0d: got st=%0d ge=%0d sc=%0d, want st=%0d ge=%0d sc=%0d",
                 i, obs[10:9], obs[8], obs[7:0], m_state, m_ge, m_score);
      end
    end
    clr = 1'b1; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_collision_hold();
    test_pass_and_hit();
    test_boundary();
    test_clr_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
